// File: rtl/day01_pkg.sv
// Shared types and constants for the day 1 input parsers.
// Holds the parser state encoding, the ASCII characters it recognises and the default delta width.
package day01_pkg;

    localparam int DEFAULT_W = 64;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    typedef enum logic [2:0] {
        S_SIGN,
        S_FIRST,
        S_DIGITS,
        S_END,
        S_ERR
    } state_t;

endpackage

// File: rtl/day01_dec_acc.sv
// Combinational decimal accumulate step: next = mag*10 + digit.
// ovf flags any result above the largest positive signed W-bit value.
module day01_dec_acc
    import day01_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] mag,
    input  logic [3:0]   digit,
    output logic [W-1:0] next_mag,
    output logic         ovf
);

    logic [W+3:0] wide;

    // Four extra bits hold mag*10+9 for any W-bit mag, so nothing is lost before the range check.
    always_comb begin
        wide = ({4'b0000, mag} * (W+4)'(10)) + {{W{1'b0}}, digit};
    end

    assign next_mag = wide[W-1:0];
    assign ovf      = |wide[W+3:W-1];

endmodule

// File: rtl/day01_delta_parser.sv
// ASCII line parser turning "+N"/"-N" lines into signed deltas on a valid/ready stream,
// with a delta count, sticky done once the final delta is taken, and sticky err.
module day01_delta_parser
    import day01_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_byte,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_delta,
    output logic          out_last,
    output logic [CW-1:0] out_count,
    output logic          done,
    output logic          err
);

    state_t       state, next_state;
    logic [W-1:0] mag, mag_nxt, acc_mag, emit_mag;
    logic         neg, neg_nxt;
    logic         acc_ovf, is_digit, is_nl, is_cr, is_sign;
    logic [3:0]   digit;
    logic         in_xfer, out_xfer;
    logic         emit, emit_last, blank_done;

    assign is_digit = (in_byte >= CH_0) && (in_byte <= CH_9);
    assign digit    = is_digit ? in_byte[3:0] : 4'd0;
    assign is_nl    = (in_byte == CH_NL);
    assign is_cr    = (in_byte == CH_CR);
    assign is_sign  = (in_byte == CH_PLUS) || (in_byte == CH_MINUS);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    day01_dec_acc #(.W(W)) u_acc (
        .mag      (mag),
        .digit    (digit),
        .next_mag (acc_mag),
        .ovf      (acc_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SIGN;
        end else begin
            state <= next_state;
        end
    end

    // A digit carrying in_last on a multi-digit line finishes it, so emit_mag takes the updated value.
    always_comb begin
        next_state = state;
        mag_nxt    = mag;
        neg_nxt    = neg;
        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_mag   = mag;
        blank_done = 1'b0;
        if (in_xfer) begin
            case (state)
                S_SIGN: begin
                    if (is_sign) begin
                        neg_nxt    = (in_byte == CH_MINUS);
                        mag_nxt    = '0;
                        next_state = in_last ? S_ERR : S_FIRST;
                    end else if (is_nl || is_cr) begin
                        if (in_last) begin
                            blank_done = 1'b1;
                            next_state = S_END;
                        end
                    end else begin
                        next_state = S_ERR;
                    end
                end
                S_FIRST: begin
                    if (is_digit && !in_last) begin
                        mag_nxt    = {{(W-4){1'b0}}, digit};
                        next_state = S_DIGITS;
                    end else begin
                        next_state = S_ERR;
                    end
                end
                S_DIGITS: begin
                    if (is_digit) begin
                        if (acc_ovf) begin
                            next_state = S_ERR;
                        end else begin
                            mag_nxt = acc_mag;
                            if (in_last) begin
                                emit       = 1'b1;
                                emit_last  = 1'b1;
                                emit_mag   = acc_mag;
                                next_state = S_END;
                            end
                        end
                    end else if (is_nl || (is_cr && in_last)) begin
                        emit       = 1'b1;
                        emit_last  = in_last;
                        next_state = in_last ? S_END : S_SIGN;
                    end else if (!is_cr) begin
                        next_state = S_ERR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        err      = (state == S_ERR);
        in_ready = (state == S_ERR) || ((state != S_END) && (!out_valid || out_ready));
    end

    // Entering S_ERR drops any delta still waiting for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_delta <= '0;
            out_count <= '0;
            done      <= 1'b0;
        end else begin
            mag <= mag_nxt;
            neg <= neg_nxt;
            if (out_xfer) begin
                out_count <= out_count + CW'(1);
            end
            if (next_state == S_ERR) begin
                out_valid <= 1'b0;
            end else if (emit) begin
                out_valid <= 1'b1;
                out_delta <= neg ? -emit_mag : emit_mag;
                out_last  <= emit_last;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
            if (blank_done || (out_xfer && out_last)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_day01_delta_parser.sv
// Directed self-checking bench for day01_delta_parser: streams ASCII lines and
// compares every delivered delta, count and status flag against hand-computed values.
module tb_day01_delta_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_byte;
    logic        out_valid, out_ready, out_last;
    logic [63:0] out_delta;
    logic [31:0] out_count;
    logic        done, err;

    int checks = 0;
    int passes = 0;
    logic [63:0] gotDelta[$];
    logic        gotLast[$];

    always #5 clk = ~clk;

    day01_delta_parser #(.W(64), .CW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_delta (out_delta),
        .out_last  (out_last),
        .out_count (out_count),
        .done      (done),
        .err       (err)
    );

    // Inputs only move just after a rising edge, so the falling edge sees what the next edge will take.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            gotDelta.push_back(out_delta);
            gotLast.push_back(out_last);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic last);
        int n;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendString(input string s, input logic lastOnEnd);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], lastOnEnd && (i == s.len() - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b1;
        idle(2);
        gotDelta.delete();
        gotLast.delete();
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] deltaAt(input int i);
        return (gotDelta.size() > i) ? gotDelta[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic logic [63:0] lastAt(input int i);
        return (gotLast.size() > i) ? 64'(gotLast[i]) : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    initial begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        idle(2);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_out_delta", out_delta, 64'd0);
        checkOutput("rst_out_count", 64'(out_count), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;

        // Basic three-line stream ending with in_last on the final newline.
        sendString("+7\n-3\n+1\n", 1'b1);
        idle(4);
        checkOutput("t1_count_q", 64'(gotDelta.size()), 64'd3);
        checkOutput("t1_d0", deltaAt(0), 64'd7);
        checkOutput("t1_d1", deltaAt(1), -64'd3);
        checkOutput("t1_d2", deltaAt(2), 64'd1);
        checkOutput("t1_l0", lastAt(0), 64'd0);
        checkOutput("t1_l1", lastAt(1), 64'd0);
        checkOutput("t1_l2", lastAt(2), 64'd1);
        checkOutput("t1_out_count", 64'(out_count), 64'd3);
        checkOutput("t1_done", 64'(done), 64'd1);
        checkOutput("t1_in_ready_end", 64'(in_ready), 64'd0);
        checkOutput("t1_err", 64'(err), 64'd0);

        // Same stream with the consumer stalled for five cycles after the first delta.
        doReset();
        fork
            sendString("+7\n-3\n+1\n", 1'b1);
            begin
                for (int n = 0; n < 40; n++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("t2_stall_in_ready", 64'(in_ready), 64'd0);
                    checkOutput("t2_stall_hold", out_delta, 64'd7);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        checkOutput("t2_count_q", 64'(gotDelta.size()), 64'd3);
        checkOutput("t2_d0", deltaAt(0), 64'd7);
        checkOutput("t2_d1", deltaAt(1), -64'd3);
        checkOutput("t2_d2", deltaAt(2), 64'd1);
        checkOutput("t2_l2", lastAt(2), 64'd1);
        checkOutput("t2_out_count", 64'(out_count), 64'd3);
        checkOutput("t2_done", 64'(done), 64'd1);

        // Negative zero, CRLF, a blank line and the largest positive value ending on a digit.
        doReset();
        sendString("-0\015\n\n+9223372036854775807", 1'b1);
        idle(4);
        checkOutput("t3_count_q", 64'(gotDelta.size()), 64'd2);
        checkOutput("t3_d0", deltaAt(0), 64'd0);
        checkOutput("t3_l0", lastAt(0), 64'd0);
        checkOutput("t3_d1", deltaAt(1), 64'h7FFF_FFFF_FFFF_FFFF);
        checkOutput("t3_l1", lastAt(1), 64'd1);
        checkOutput("t3_out_count", 64'(out_count), 64'd2);
        checkOutput("t3_done", 64'(done), 64'd1);

        // One past the largest positive value must overflow on the final digit.
        doReset();
        sendString("+922337203685477580", 1'b0);
        checkOutput("t4_err_before", 64'(err), 64'd0);
        applyStimulus("8", 1'b0);
        checkOutput("t4_err_ovf", 64'(err), 64'd1);
        checkOutput("t4_in_ready", 64'(in_ready), 64'd1);
        applyStimulus("\n", 1'b0);
        idle(2);
        checkOutput("t4_no_delta", 64'(gotDelta.size()), 64'd0);
        checkOutput("t4_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t4_out_count", 64'(out_count), 64'd0);
        checkOutput("t4_err_sticky", 64'(err), 64'd1);
        checkOutput("t4_in_ready_drain", 64'(in_ready), 64'd1);

        // Bad character mid-number.
        doReset();
        sendString("+12", 1'b0);
        checkOutput("t5_err_before", 64'(err), 64'd0);
        applyStimulus("x", 1'b0);
        checkOutput("t5_err_x", 64'(err), 64'd1);
        applyStimulus("\n", 1'b0);
        idle(2);
        checkOutput("t5_no_delta", 64'(gotDelta.size()), 64'd0);

        // Truncated input: a lone sign carrying in_last.
        doReset();
        applyStimulus("+", 1'b1);
        idle(3);
        checkOutput("t6_err", 64'(err), 64'd1);
        checkOutput("t6_done", 64'(done), 64'd0);
        checkOutput("t6_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a line, then a fresh line.
        doReset();
        sendString("+5\n+45", 1'b0);
        checkOutput("t7_count_pre", 64'(out_count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_count", 64'(out_count), 64'd0);
        checkOutput("t7_rst_delta", out_delta, 64'd0);
        checkOutput("t7_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t7_rst_last", 64'(out_last), 64'd0);
        checkOutput("t7_rst_done", 64'(done), 64'd0);
        checkOutput("t7_rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        gotDelta.delete();
        gotLast.delete();
        rst_n = 1'b1;
        sendString("-2\n", 1'b0);
        idle(3);
        checkOutput("t7_count_q", 64'(gotDelta.size()), 64'd1);
        checkOutput("t7_d0", deltaAt(0), -64'd2);
        checkOutput("t7_l0", lastAt(0), 64'd0);
        checkOutput("t7_out_count", 64'(out_count), 64'd1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
